fb_line_fetcher: RTL and testbench

FB_LINE_FETCHER -- requirements
Module: fb_line_fetcher

---
 rtl/fb_line_fetcher.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_fb_line_fetcher.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_line_fetcher.sv
// fb_line_fetcher
//
// Fetches a frame buffer over an AXI read master, one line at a time, and
// streams it out as 24-bit pixels on a valid/ready port.
//
// Ports
//   pixel_clk, rst             single clock, synchronous active-high reset
//   frame_start                pulse; starts a frame when the block is idle
//   fb_base_addr, fb_stride    frame base byte address and line pitch
//   fb_width, fb_height        frame geometry in pixels / lines
//   pixel_format               1 = RGB565, anything else = RGBA8888
//   busy, frame_done           frame in progress / last-pixel pulse
//   rresp_err                  sticky flag for a non-OKAY read response
//   px_valid/px_ready/px_rgb/px_flags   pixel stream, flags = {sof, sol, eol}
//   m_ar*, m_r*                AXI read address and read data channels
//   dbg_state                  current fetch FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A valid, once raised, holds its payload stable until the transfer; valid
// never depends combinationally on the matching ready.
module fb_line_fetcher #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int BURST_LEN      = 16,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      pixel_clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] fb_base_addr,
    input  logic [31:0]               fb_stride,
    input  logic [11:0]               fb_width,
    input  logic [11:0]               fb_height,
    input  logic [1:0]                pixel_format,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      rresp_err,
    output logic                      px_valid,
    input  logic                      px_ready,
    output logic [23:0]               px_rgb,
    output logic [2:0]                px_flags,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic [1:0]                dbg_state
);

    localparam int BPB   = AXI_DATA_WIDTH / 8;   // bytes per beat
    localparam int SIZE  = $clog2(BPB);
    localparam int PPW16 = AXI_DATA_WIDTH / 16;  // RGB565 pixels per word
    localparam int PPW32 = AXI_DATA_WIDTH / 32;  // RGBA8888 pixels per word
    localparam int SW    = $clog2(PPW16);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched frame configuration
    logic [31:0]               r_stride;
    logic [11:0]               r_width;
    logic [11:0]               r_height;
    logic                      r_fmt16;
    logic [15:0]               r_bpl;

    // Request side
    logic [AXI_ADDR_WIDTH-1:0] r_line_addr;
    logic [AXI_ADDR_WIDTH-1:0] r_burst_addr;
    logic [15:0]               r_beats_left;
    logic [11:0]               r_req_line;
    logic [15:0]               r_credits;

    // Beat FIFO
    logic [AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]               r_wr_ptr;
    logic [AW:0]               r_rd_ptr;

    // Unpacker position
    logic [11:0]               r_x;
    logic [11:0]               r_y;
    logic [SW-1:0]             r_slot;

    logic                      w_accept;
    logic [15:0]               w_line_bytes;
    logic [15:0]               w_bpl_in;
    logic [4:0]                w_beats;
    logic                      w_credit_ok;
    logic                      w_ar_fire;
    logic                      w_burst_last;
    logic                      w_line_last;
    logic [AXI_ADDR_WIDTH-1:0] w_stride_a;
    logic [AXI_ADDR_WIDTH-1:0] w_burst_bytes;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic [AXI_DATA_WIDTH-1:0] w_head;
    logic [15:0]               w_lane16 [PPW16];
    logic [23:0]               w_lane32 [PPW32];
    logic [15:0]               w_p16;
    logic [23:0]               w_p32;
    logic [SW-1:0]             w_slot_max;
    logic                      w_last_x;
    logic                      w_last_y;
    logic                      w_px_fire;

    assign w_accept = (r_state == S_IDLE) && frame_start;

    // Beats per line: line bytes rounded up to whole bus words.
    assign w_line_bytes = (pixel_format == 2'd1) ? {3'b000, fb_width, 1'b0}
                                                 : {2'b00, fb_width, 2'b00};
    assign w_bpl_in     = (w_line_bytes + 16'(BPB - 1)) >> SIZE;

    assign w_beats       = (r_beats_left >= 16'(BURST_LEN)) ? 5'(BURST_LEN) : r_beats_left[4:0];
    assign w_credit_ok   = r_credits >= {11'b0, w_beats};
    assign w_burst_last  = r_beats_left == {11'b0, w_beats};
    assign w_line_last   = r_req_line == (r_height - 12'd1);
    assign w_stride_a    = AXI_ADDR_WIDTH'(r_stride);
    assign w_burst_bytes = AXI_ADDR_WIDTH'(w_beats) << SIZE;
    assign w_ar_fire     = m_arvalid && m_arready;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        m_arvalid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) w_state_next = S_REQ;
            end
            S_REQ: begin
                // Credits only grow while waiting, so arvalid cannot drop
                // before arready once it has been raised.
                m_arvalid = w_credit_ok;
                if (w_credit_ok && m_arready && w_burst_last && w_line_last)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (frame_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign m_araddr  = r_burst_addr;
    assign m_arlen   = {3'b000, w_beats - 5'd1};
    assign m_arsize  = 3'(SIZE);
    assign m_arburst = 2'b01;
    assign m_rready  = busy;

    // ---------------- request datapath ----------------
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_stride     <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_fmt16      <= 1'b0;
            r_bpl        <= '0;
            r_line_addr  <= '0;
            r_burst_addr <= '0;
            r_beats_left <= '0;
            r_req_line   <= '0;
        end else if (w_accept) begin
            r_stride     <= fb_stride;
            r_width      <= fb_width;
            r_height     <= fb_height;
            r_fmt16      <= (pixel_format == 2'd1);
            r_bpl        <= w_bpl_in;
            r_line_addr  <= fb_base_addr;
            r_burst_addr <= fb_base_addr;
            r_beats_left <= w_bpl_in;
            r_req_line   <= '0;
        end else if (w_ar_fire) begin
            if (w_burst_last) begin
                r_line_addr  <= r_line_addr + w_stride_a;
                r_burst_addr <= r_line_addr + w_stride_a;
                r_beats_left <= r_bpl;
                r_req_line   <= r_req_line + 12'd1;
            end else begin
                r_burst_addr <= r_burst_addr + w_burst_bytes;
                r_beats_left <= r_beats_left - {11'b0, w_beats};
            end
        end
    end

    // One credit per free FIFO slot, reserved in bulk when a burst is issued.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_credits <= 16'(FIFO_DEPTH);
        end else begin
            r_credits <= r_credits - (w_ar_fire ? {11'b0, w_beats} : 16'd0)
                                   + (w_pop ? 16'd1 : 16'd0);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            rresp_err <= 1'b0;
        end else if (w_accept) begin
            rresp_err <= 1'b0;
        end else if (w_push && (m_rresp != 2'b00)) begin
            rresp_err <= 1'b1;
        end
    end

    // ---------------- beat FIFO ----------------
    assign w_push  = m_rvalid && m_rready;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= m_rdata;
    end

    // ---------------- unpacker ----------------
    // The pixel is presented straight from the FIFO head; the head word and
    // slot only change on a handshake, which keeps the output stable.
    for (genvar g = 0; g < PPW16; g++) begin : g_lane16
        assign w_lane16[g] = w_head[g*16 +: 16];
    end
    for (genvar g = 0; g < PPW32; g++) begin : g_lane32
        assign w_lane32[g] = w_head[g*32 +: 24];   // alpha byte dropped
    end

    assign w_p16      = w_lane16[r_slot];
    assign w_p32      = w_lane32[r_slot[SW-2:0]];
    assign w_slot_max = r_fmt16 ? SW'(PPW16 - 1) : SW'(PPW32 - 1);
    assign w_last_x   = (r_x == (r_width - 12'd1));
    assign w_last_y   = (r_y == (r_height - 12'd1));

    assign px_valid  = busy && !w_empty;
    assign px_rgb    = r_fmt16 ? {w_p16[15:11], w_p16[15:13],
                                  w_p16[10:5],  w_p16[10:9],
                                  w_p16[4:0],   w_p16[4:2]}
                               : {w_p32[7:0], w_p32[15:8], w_p32[23:16]};
    assign px_flags  = {(r_x == 12'd0) && (r_y == 12'd0), (r_x == 12'd0), w_last_x};
    assign w_px_fire = px_valid && px_ready;
    // A line's final word is released at its last pixel, dropping any padding.
    assign w_pop      = w_px_fire && (w_last_x || (r_slot == w_slot_max));
    assign frame_done = w_px_fire && w_last_x && w_last_y;

    always_ff @(posedge pixel_clk) begin
        if (rst || w_accept) begin
            r_x    <= '0;
            r_y    <= '0;
            r_slot <= '0;
        end else if (w_px_fire) begin
            if (w_last_x) begin
                r_x    <= '0;
                r_y    <= r_y + 12'd1;
                r_slot <= '0;
            end else begin
                r_x    <= r_x + 12'd1;
                r_slot <= (r_slot == w_slot_max) ? '0 : r_slot + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_line_fetcher.sv
module tb_fb_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [31:0] fb_base_addr;
  logic [31:0] fb_stride;
  logic [11:0] fb_width;
  logic [11:0] fb_height;
  logic [1:0]  pixel_format;
  logic        busy, frame_done, rresp_err, px_valid, px_ready;
  logic [23:0] px_rgb;
  logic [2:0]  px_flags;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;
  logic [1:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fb_line_fetcher #(
    .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .BURST_LEN(16), .FIFO_DEPTH(32)
  ) dut (
    .pixel_clk(clk), .rst(rst), .frame_start(frame_start),
    .fb_base_addr(fb_base_addr), .fb_stride(fb_stride),
    .fb_width(fb_width), .fb_height(fb_height), .pixel_format(pixel_format),
    .busy(busy), .frame_done(frame_done), .rresp_err(rresp_err),
    .px_valid(px_valid), .px_ready(px_ready), .px_rgb(px_rgb), .px_flags(px_flags),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [26:0] exp_q[$];      // {sof, sol, eol, rgb}
  logic [39:0] exp_ar_q[$];   // {araddr, arlen}
  logic [63:0] mem_ovr[logic [31:0]];
  logic [31:0] pend_addr[$];
  int          pend_left[$];
  int  done_cnt = 0;
  int  ar_cnt = 0;
  int  r_beat_cnt = 0;
  bit  err_inj = 1'b0;
  int  rdy_mode = 2;          // 0 hold low, 1 random, 2 always high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- memory model ----------------
  function automatic logic [7:0] byte_fn(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'd2654435761;
    return h[20:13] ^ a[7:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [63:0] w;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = byte_fn(a + 32'(i));
    return w;
  endfunction

  function automatic logic [23:0] model_px(input logic [31:0] base, input logic [31:0] stride,
                                           input bit f16, input int x, input int y);
    logic [31:0] a;
    logic [63:0] w;
    logic [15:0] h;
    logic [31:0] q;
    int off;
    a = base + stride * 32'(y) + 32'(x) * (f16 ? 32'd2 : 32'd4);
    w = mem_word({a[31:3], 3'b000});
    off = int'(a[2:0]);
    if (f16) begin
      h = w[off*8 +: 16];
      return {h[15:11], h[15:13], h[10:5], h[10:9], h[4:0], h[4:2]};
    end
    q = w[off*8 +: 32];
    return {q[7:0], q[15:8], q[23:16]};
  endfunction

  task automatic push_frame(input logic [31:0] base, input logic [31:0] stride,
                            input int w, input int h, input bit f16);
    int bpl, left, nb;
    logic [31:0] a;
    logic [2:0] fl;
    bpl = (w * (f16 ? 2 : 4) + 7) / 8;
    for (int y = 0; y < h; y++) begin
      a = base + stride * 32'(y);
      left = bpl;
      while (left > 0) begin
        nb = (left > 16) ? 16 : left;
        exp_ar_q.push_back({a, 8'(nb - 1)});
        a = a + 32'(nb * 8);
        left = left - nb;
      end
    end
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        fl[2] = (x == 0) && (y == 0);
        fl[1] = (x == 0);
        fl[0] = (x == w - 1);
        exp_q.push_back({fl, model_px(base, stride, f16, x, y)});
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [31:0] base, input logic [31:0] stride,
                             input int w, input int h, input logic [1:0] fmt);
    @(posedge clk); #1;
    fb_base_addr = base; fb_stride = stride;
    fb_width = 12'(w); fb_height = 12'(h); pixel_format = fmt;
    frame_start = 1'b1;
    r_beat_cnt = 0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_in_time"}, 64'(n < budget), 64'd1);
    check({name, "_px_q_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_ar_q_empty"}, 64'(exp_ar_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_frame_done"}, 64'(frame_done), 64'd0);
    check({name, "_rresp_err"}, 64'(rresp_err), 64'd0);
    check({name, "_px_valid"}, 64'(px_valid), 64'd0);
    check({name, "_arvalid"}, 64'(m_arvalid), 64'd0);
    check({name, "_rready"}, 64'(m_rready), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- pixel sink ----------------
  initial begin
    px_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: px_ready = 1'b0;
        1: px_ready = ($urandom_range(0, 3) != 0);
        default: px_ready = 1'b1;
      endcase
    end
  end

  // ---------------- pixel monitor ----------------
  initial begin
    logic [26:0] e;
    logic [26:0] prev_px;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_px = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("px_hold", {px_valid, px_flags, px_rgb}, {1'b1, prev_px});
        prev_stall = px_valid && !px_ready;
        prev_px = {px_flags, px_rgb};
        if (px_valid && px_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL px_extra: got %0h want none", {px_flags, px_rgb});
          end else begin
            e = exp_q.pop_front();
            check("px", {px_flags, px_rgb}, e);
          end
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  // ---------------- AXI slave ----------------
  initial begin
    bit ar_prev;
    logic [39:0] ar_prev_v;
    ar_prev = 1'b0;
    ar_prev_v = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_left.delete();
        ar_prev = 1'b0;
      end else begin
        if (ar_prev) check("ar_hold", {m_arvalid, m_araddr, m_arlen}, {1'b1, ar_prev_v});
        ar_prev = m_arvalid && !m_arready;
        ar_prev_v = {m_araddr, m_arlen};
        if (m_arvalid && m_arready) begin
          ar_cnt++;
          check("ar_size_burst", {m_arsize, m_arburst}, {3'd3, 2'b01});
          if (exp_ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_extra: got %0h want none", {m_araddr, m_arlen});
          end else begin
            check("ar", {m_araddr, m_arlen}, exp_ar_q.pop_front());
          end
          pend_addr.push_back(m_araddr);
          pend_left.push_back(int'(m_arlen) + 1);
        end
        if (m_rvalid && m_rready && pend_addr.size() > 0) begin
          r_beat_cnt++;
          pend_addr[0] = pend_addr[0] + 32'd8;
          pend_left[0] = pend_left[0] - 1;
          if (pend_left[0] == 0) begin
            void'(pend_addr.pop_front());
            void'(pend_left.pop_front());
          end
        end
      end
      @(posedge clk); #1;
      m_arready = ($urandom_range(0, 3) != 0);
      if (!rst && pend_addr.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_rvalid = 1'b1;
        m_rdata = mem_word(pend_addr[0]);
        m_rresp = (err_inj && r_beat_cnt == 3) ? 2'd2 : 2'd0;
      end else begin
        m_rvalid = 1'b0;
        m_rresp = 2'b00;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ar0, n;
    rst = 1'b1; frame_start = 1'b0;
    fb_base_addr = '0; fb_stride = '0; fb_width = 12'd1; fb_height = 12'd1; pixel_format = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // RGB565, width 5: two beats in one burst, three padding pixels dropped.
    rdy_mode = 2;
    mem_ovr[32'h0000_4000] = 64'h1234_07E0_001F_F800;
    mem_ovr[32'h0000_4008] = 64'hAAAA_BBBB_CCCC_FFFF;
    exp_ar_q.push_back({32'h0000_4000, 8'd1});
    exp_q.push_back({3'b110, 24'hFF0000});
    exp_q.push_back({3'b000, 24'h0000FF});
    exp_q.push_back({3'b000, 24'h00FF00});
    exp_q.push_back({3'b000, 24'h1045A5});
    exp_q.push_back({3'b001, 24'hFFFFFF});
    pulse_start(32'h0000_4000, 32'h0000_0100, 5, 1, 2'd1);
    check("565_busy", 64'(busy), 64'd1);
    wait_idle("565", 200);
    check("565_done_cnt", 64'(done_cnt), 64'd1);
    check("565_px_valid_after", 64'(px_valid), 64'd0);

    // Error response on beat 3; frame still completes.
    rdy_mode = 1;
    err_inj = 1'b1;
    push_frame(32'h0003_0000, 32'd256, 7, 3, 1'b0);
    pulse_start(32'h0003_0000, 32'd256, 7, 3, 2'd0);
    wait_idle("err", 500);
    err_inj = 1'b0;
    check("err_flag", 64'(rresp_err), 64'd1);
    check("err_done_cnt", 64'(done_cnt), 64'd2);

    // Reserved format behaves as RGBA; 17 beats -> bursts of 16 and 1.
    push_frame(32'h0005_0000, 32'd256, 33, 2, 1'b0);
    pulse_start(32'h0005_0000, 32'd256, 33, 2, 2'd2);
    check("err_cleared", 64'(rresp_err), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    pulse_start(32'h0F00_0000, 32'd512, 9, 9, 2'd1);   // must be ignored
    check("ignored_start_busy", 64'(busy), 64'd1);
    wait_idle("rsvd", 1000);
    check("rsvd_done_cnt", 64'(done_cnt), 64'd3);

    // Full-size RGBA line pair.
    push_frame(32'h1000_0000, 32'd8192, 1920, 2, 1'b0);
    pulse_start(32'h1000_0000, 32'd8192, 1920, 2, 2'd0);
    wait_idle("hd", 20000);
    check("hd_done_cnt", 64'(done_cnt), 64'd4);

    // Reset in the middle of a burst.
    err_inj = 1'b1;
    push_frame(32'h2000_0000, 32'd256, 64, 4, 1'b0);
    pulse_start(32'h2000_0000, 32'd256, 64, 4, 2'd0);
    n = 0;
    while (r_beat_cnt < 5 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_beats_in_time", 64'(n < 300), 64'd1);
    check("abort_err_set", 64'(rresp_err), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("abort");
    err_inj = 1'b0;
    exp_q.delete();
    exp_ar_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_done_cnt", 64'(done_cnt), 64'd4);

    // Stalled sink: only the credited bursts may be issued.
    rdy_mode = 0;
    ar0 = ar_cnt;
    push_frame(32'h3000_0000, 32'd8192, 1920, 1, 1'b0);
    pulse_start(32'h3000_0000, 32'd8192, 1920, 1, 2'd0);
    repeat (200) @(posedge clk);
    #1;
    check("stall_ar_count", 64'(ar_cnt - ar0), 64'd2);
    check("stall_arvalid", 64'(m_arvalid), 64'd0);
    check("stall_px_valid", 64'(px_valid), 64'd1);
    rdy_mode = 1;
    wait_idle("stall", 10000);
    check("stall_done_cnt", 64'(done_cnt), 64'd5);
    check("stall_state", 64'(dbg_state), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
